// File: rtl/rxstr_match_pkg.sv
// Shared constants for the fixed-string UART receiver: baud divisors,
// the reference string and the receiver/matcher state encodings.
package rxstr_match_pkg;

  // clk cycles per bit at 12 MHz
  localparam int unsigned B9600 = 1250;

  localparam logic [7:0] CHR_DOT = 8'h2E;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Matcher state = number of string chars matched so far
  typedef enum logic [2:0] {
    M_GOT0, M_GOT1, M_GOT2, M_GOT3,
    M_GOT4, M_GOT5, M_GOT6, M_GOT7
  } match_state_e;

  // Reference string ".Hello!." indexed 0..7
  function automatic logic [7:0] str_char(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = 8'h2E;
      3'd1:    c = 8'h48;
      3'd2:    c = 8'h65;
      3'd3:    c = 8'h6C;
      3'd4:    c = 8'h6C;
      3'd5:    c = 8'h6F;
      3'd6:    c = 8'h21;
      default: c = 8'h2E;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rxstr_match_if.sv
// Serial input and match/status outputs of the string receiver.
interface rxstr_match_if;
  logic       rx;
  logic       match;
  logic [2:0] progress;
  logic [7:0] last_char;
  logic       rcv;
  logic       frame_err;

  modport master (
    output rx,
    input  match, progress, last_char, rcv, frame_err
  );

  modport slave (
    input  rx,
    output match, progress, last_char, rcv, frame_err
  );
endinterface

// File: rtl/rxstr_match_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, start/data/stop FSM, baud and bit
// counters. Emits one-cycle rcv or frame_err pulses per frame.
module rxstr_match_uart_rx
  import rxstr_match_pkg::*;
#(
  parameter int unsigned BAUDRATE = B9600
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(BAUDRATE);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUDRATE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUDRATE - 1);

  logic          rx_s1_q, rx_s2_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          rcv_q, rcv_d;
  logic          ferr_q, ferr_d;

  // Synchroniser for the asynchronous pad input; presets to idle-high
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  // Receiver state, counters and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= RX_IDLE;
      baud_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      rcv_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      rcv_q    <= rcv_d;
      ferr_q   <= ferr_d;
    end
  end

  // Next-state: half-bit wait to mid start bit, then full-bit sample spacing
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    rcv_d    = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        baud_d = '0;
        if (!rx_s2_q) state_d = RX_START;
      end
      RX_START: begin
        if (baud_q == HALF_M1) begin
          baud_d = '0;
          if (rx_s2_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d  = RX_DATA;
            bitcnt_d = '0;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          if (bitcnt_q == 3'd7) state_d = RX_STOP;
          else                  bitcnt_d = bitcnt_q + 3'd1;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          state_d = RX_IDLE;
          if (rx_s2_q) begin
            rcv_d  = 1'b1;
            data_d = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data      = data_q;
  assign rcv       = rcv_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/rxstr_match.sv
// Fixed-string UART receiver: deserialises bytes and pulses match whenever
// the last eight received bytes spell ".Hello!.".
module rxstr_match
  import rxstr_match_pkg::*;
#(
  parameter int unsigned BAUDRATE = B9600
) (
  input  logic          clk,
  input  logic          rstn,
  rxstr_match_if.slave  bus
);

  logic [7:0]   rx_data;
  logic         rx_rcv;
  logic         rx_ferr;
  match_state_e prog_q, prog_d;
  logic         match_q, match_d;

  rxstr_match_uart_rx #(.BAUDRATE(BAUDRATE)) u_rx (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (bus.rx),
    .data      (rx_data),
    .rcv       (rx_rcv),
    .frame_err (rx_ferr)
  );

  // Matcher state and registered match pulse
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prog_q  <= M_GOT0;
      match_q <= 1'b0;
    end else begin
      prog_q  <= prog_d;
      match_q <= match_d;
    end
  end

  // A completed string leaves progress at 1: its final '.' opens the next one
  always_comb begin
    prog_d  = prog_q;
    match_d = 1'b0;
    if (rx_ferr) begin
      prog_d = M_GOT0;
    end else if (rx_rcv) begin
      if (rx_data == str_char(prog_q)) begin
        if (prog_q == M_GOT7) begin
          match_d = 1'b1;
          prog_d  = M_GOT1;
        end else begin
          prog_d = match_state_e'(prog_q + 3'd1);
        end
      end else begin
        prog_d = (rx_data == CHR_DOT) ? M_GOT1 : M_GOT0;
      end
    end
  end

  assign bus.match     = match_q;
  assign bus.progress  = prog_q;
  assign bus.last_char = rx_data;
  assign bus.rcv       = rx_rcv;
  assign bus.frame_err = rx_ferr;

endmodule

// File: tb/tb_rxstr_match.sv
// Directed bench for rxstr_match at 16 clk/bit. A string-level model
// (history of good bytes, longest suffix that is a prefix of ".Hello!.")
// is compared with the DUT outputs every cycle.
module tb_rxstr_match;

  localparam int unsigned B = 16;
  // posedge before the start-bit fall to the cycle rcv is visible:
  // 2 sync clks + idle detect + half bit + 9 bits
  localparam int unsigned LAT = 3 + B / 2 + 9 * B;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  rxstr_match_if bus();

  rxstr_match #(.BAUDRATE(B)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    bit          ferr;
    logic [7:0]  b;
    int unsigned due;
  } ev_t;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  int          n_match = 0;
  logic        rst_smp;

  ev_t         evq[$];
  logic [7:0]  hist[$];
  logic [7:0]  str_b [8] = '{8'h2E, 8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h2E};
  logic [7:0]  exp_last = 8'h00;
  bit          exp_match;
  int          exp_prog;
  bit          pend = 1'b0;
  bit          pend_ferr;
  logic [7:0]  pend_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit ends_with_str();
    int n = hist.size();
    if (n < 8) return 1'b0;
    for (int i = 0; i < 8; i++)
      if (hist[n-8+i] != str_b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int calc_prog();
    int n = hist.size();
    for (int k = 7; k >= 1; k--) begin
      bit ok = (n >= k);
      for (int i = 0; i < k && ok; i++)
        if (hist[n-k+i] != str_b[i]) ok = 1'b0;
      if (ok) return k;
    end
    return 0;
  endfunction

  function automatic void take_event(input ev_t e);
    if (!e.ferr) exp_last = e.b;
    pend      = 1'b1;
    pend_ferr = e.ferr;
    pend_b    = e.b;
  endfunction

  // Per-cycle compare against the model; outputs sampled on the falling edge
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      cyc++;
      rst_smp = rstn;
      @(negedge clk);
      exp_match = 1'b0;
      if (!rst_smp) begin
        hist.delete();
        exp_last = 8'h00;
        pend     = 1'b0;
        chk("reset_rcv", bus.rcv, 1'b0);
        chk("reset_frame_err", bus.frame_err, 1'b0);
      end else if (pend) begin
        if (pend_ferr) begin
          hist.delete();
        end else begin
          hist.push_back(pend_b);
          if (hist.size() > 8) void'(hist.pop_front());
          exp_match = ends_with_str();
        end
        pend = 1'b0;
      end
      exp_prog = calc_prog();

      if (rst_smp && (bus.rcv === 1'b1 || bus.frame_err === 1'b1)) begin
        if (evq.size() == 0) begin
          chk("unexpected_pulse", {bus.rcv, bus.frame_err}, 2'b00);
        end else begin
          e = evq.pop_front();
          chk("pulse_is_frame_err", bus.frame_err, e.ferr);
          total++;
          if (!(cyc + 1 >= e.due && cyc <= e.due + 1)) begin
            bad++;
            $display("FAIL pulse_latency: got cycle %0d expected %0d+-1", cyc, e.due);
          end
          take_event(e);
        end
      end else if (evq.size() != 0 && cyc > evq[0].due + 1) begin
        e = evq.pop_front();
        chk("pulse_missing", 1'b0, 1'b1);
        take_event(e);
      end

      chk("rcv_ferr_exclusive", bus.rcv & bus.frame_err, 1'b0);
      chk("match", bus.match, exp_match);
      chk("progress", bus.progress, exp_prog);
      chk("last_char", bus.last_char, exp_last);
      if (bus.match === 1'b1) n_match++;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; abort_bit >= 0 pulses rstn in the middle of that data bit
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int abort_bit);
    @(posedge clk);
    #1;
    bus.rx = 1'b0;
    if (abort_bit < 0) evq.push_back('{ferr: !stop_ok, b: b, due: cyc + LAT});
    hold(B);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      if (i == abort_bit) begin
        hold(B / 2);
        rstn   = 1'b0;
        bus.rx = 1'b1;
        hold(4);
        rstn = 1'b1;
        hold(3 * B);
        return;
      end
      hold(B);
    end
    bus.rx = stop_ok;
    if (stop_ok) begin
      hold(B);
    end else begin
      hold(10);
      bus.rx = 1'b1;
      hold(B);
    end
    hold(2);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, -1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rstn   = 1'b0;
    bus.rx = 1'b1;
    hold(5);
    chk("reset_match", bus.match, 1'b0);
    chk("reset_progress", bus.progress, 3'd0);
    chk("reset_last_char", bus.last_char, 8'h00);
    rstn = 1'b1;
    hold(3);

    // 1: single string
    n_match = 0;
    send_str(".He");
    chk("t1_progress_after_He", bus.progress, 3'd3);
    send_str("llo!.");
    hold(4);
    chk("t1_match_count", n_match, 1);
    chk("t1_last_char", bus.last_char, 8'h2E);
    chk("t1_progress_end", bus.progress, 3'd1);

    // 2: '.' restarts, mismatch clears, then a clean string
    n_match = 0;
    send_str("..H");
    chk("t2_progress_dotdotH", bus.progress, 3'd2);
    send_str("el");
    chk("t2_progress_Hel", bus.progress, 3'd4);
    send_str("x");
    chk("t2_progress_after_x", bus.progress, 3'd0);
    send_str(".Hello!.");
    hold(4);
    chk("t2_match_count", n_match, 1);

    // 3: back-to-back strings sharing the '.'
    n_match = 0;
    send_str(".Hello!.Hello!.");
    hold(4);
    chk("t3_match_count", n_match, 2);

    // 4: framing error
    send_byte(8'h48, 1'b0, -1);
    hold(4);
    chk("t4_progress", bus.progress, 3'd0);
    chk("t4_last_char", bus.last_char, 8'h2E);

    // 5: short low glitch rejected, next byte clean
    @(posedge clk);
    #1;
    bus.rx = 1'b0;
    hold(4);
    bus.rx = 1'b1;
    hold(3 * B);
    chk("t5_last_char_after_glitch", bus.last_char, 8'h2E);
    send_byte(8'h41, 1'b1, -1);
    chk("t5_last_char", bus.last_char, 8'h41);

    // 6: reset during data bit 4 of 'l'
    n_match = 0;
    send_str(".Hel");
    send_byte(8'h6C, 1'b1, 4);
    chk("t6_progress_after_reset", bus.progress, 3'd0);
    chk("t6_last_char_after_reset", bus.last_char, 8'h00);
    send_str(".Hello!.");
    hold(4);
    chk("t6_match_count", n_match, 1);

    hold(2 * LAT);
    chk("events_drained", evq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
